// File: rtl/udl_ctrl_pkg.sv
// Shared types and helpers for the UDL_Count command sequencer.
package udl_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_UP    = 2'b01,
    OP_DOWN  = 2'b10,
    OP_SWEEP = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_STEP_UP  = 3'd2,
    ST_STEP_DN  = 3'd3,
    ST_SWEEP_UP = 3'd4,
    ST_SWEEP_DN = 3'd5,
    ST_DONE     = 3'd6
  } state_t;

  // Largest count representable in a counter of the given width (width < 32).
  function automatic int unsigned max_val(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/udl_count_ctrl.sv
// Command sequencer driving an up/down/load counter; keeps a shadow count so
// stepping stops at 0 / MAX and sweeps return exactly to their start value.
module udl_count_ctrl
  import udl_ctrl_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic             i_clk,
  input  logic             i_rst,        // asynchronous, active-low
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [1:0]       i_cmd_op,
  input  logic [WIDTH-1:0] i_cmd_arg,
  input  logic             i_abort,
  input  logic [WIDTH-1:0] i_cnt_q,
  output logic             o_up,
  output logic             o_down,
  output logic             o_load,
  output logic [WIDTH-1:0] o_in,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_sat
);

  localparam logic [WIDTH-1:0] MAX  = WIDTH'(max_val(WIDTH));
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_next;
  op_t              w_op;
  logic             w_accept;
  logic             w_set_sat;
  logic [WIDTH-1:0] w_shadow_inc;
  logic [WIDTH-1:0] w_shadow_dec;
  logic [WIDTH-1:0] w_rem_dec;

  logic [WIDTH-1:0] r_arg;
  logic [WIDTH-1:0] r_shadow;
  logic [WIDTH-1:0] r_start;
  logic [WIDTH-1:0] r_remaining;
  logic             r_ready;
  logic             r_up;
  logic             r_down;
  logic             r_load;
  logic [WIDTH-1:0] r_in;
  logic             r_busy;
  logic             r_done;
  logic             r_sat;

  assign w_op         = op_t'(i_cmd_op);
  assign w_accept     = i_cmd_valid & r_ready;
  assign w_shadow_inc = r_shadow + ONE;
  assign w_shadow_dec = r_shadow - ONE;
  assign w_rem_dec    = r_remaining - ONE;

  // Next-state decode. Being in a STEP_*/SWEEP_* state means exactly one
  // strobe is issued that cycle, so every limit is resolved one edge early.
  always_comb begin
    w_next    = r_state;
    w_set_sat = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          case (w_op)
            OP_LOAD: w_next = ST_LOAD;
            OP_UP: begin
              if (i_cmd_arg == ZERO) begin
                w_next = ST_DONE;
              end else if (i_cnt_q == MAX) begin
                w_next    = ST_DONE;
                w_set_sat = 1'b1;
              end else begin
                w_next = ST_STEP_UP;
              end
            end
            OP_DOWN: begin
              if (i_cmd_arg == ZERO) begin
                w_next = ST_DONE;
              end else if (i_cnt_q == ZERO) begin
                w_next    = ST_DONE;
                w_set_sat = 1'b1;
              end else begin
                w_next = ST_STEP_DN;
              end
            end
            OP_SWEEP: begin
              if (i_cmd_arg > i_cnt_q) w_next = ST_SWEEP_UP;
              else                     w_next = ST_DONE;
            end
            default: w_next = ST_IDLE;
          endcase
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_LOAD: w_next = ST_DONE;
      ST_STEP_UP: begin
        if (i_abort || (w_rem_dec == ZERO)) begin
          w_next = ST_DONE;
        end else if (w_shadow_inc == MAX) begin
          w_next    = ST_DONE;
          w_set_sat = 1'b1;
        end else begin
          w_next = ST_STEP_UP;
        end
      end
      ST_STEP_DN: begin
        if (i_abort || (w_rem_dec == ZERO)) begin
          w_next = ST_DONE;
        end else if (w_shadow_dec == ZERO) begin
          w_next    = ST_DONE;
          w_set_sat = 1'b1;
        end else begin
          w_next = ST_STEP_DN;
        end
      end
      ST_SWEEP_UP: begin
        if (i_abort)                     w_next = ST_DONE;
        else if (w_shadow_inc == r_arg)  w_next = ST_SWEEP_DN;
        else                             w_next = ST_SWEEP_UP;
      end
      ST_SWEEP_DN: begin
        if (i_abort || (w_shadow_dec == r_start)) w_next = ST_DONE;
        else                                      w_next = ST_SWEEP_DN;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // State register and outputs registered from the next state.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b0;
      r_up    <= 1'b0;
      r_down  <= 1'b0;
      r_load  <= 1'b0;
      r_in    <= ZERO;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == ST_IDLE);
      r_up    <= (w_next == ST_STEP_UP) || (w_next == ST_SWEEP_UP);
      r_down  <= (w_next == ST_STEP_DN) || (w_next == ST_SWEEP_DN);
      r_load  <= (w_next == ST_LOAD);
      r_in    <= (w_next == ST_LOAD) ? i_cmd_arg : ZERO;
      r_busy  <= (w_next != ST_IDLE);
      r_done  <= (w_next == ST_DONE);
    end
  end

  // Command datapath: shadow count, sweep start, remaining steps, saturation.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_arg       <= ZERO;
      r_shadow    <= ZERO;
      r_start     <= ZERO;
      r_remaining <= ZERO;
      r_sat       <= 1'b0;
    end else if (w_accept) begin
      r_arg       <= i_cmd_arg;
      r_shadow    <= i_cnt_q;
      r_start     <= i_cnt_q;
      r_remaining <= i_cmd_arg;
      r_sat       <= w_set_sat;
    end else begin
      case (r_state)
        ST_LOAD: r_shadow <= r_arg;
        ST_STEP_UP: begin
          r_shadow    <= w_shadow_inc;
          r_remaining <= w_rem_dec;
        end
        ST_STEP_DN: begin
          r_shadow    <= w_shadow_dec;
          r_remaining <= w_rem_dec;
        end
        ST_SWEEP_UP: r_shadow <= w_shadow_inc;
        ST_SWEEP_DN: r_shadow <= w_shadow_dec;
        default:     r_shadow <= r_shadow;
      endcase
      if (w_set_sat) r_sat <= 1'b1;
      else           r_sat <= r_sat;
    end
  end

  assign o_cmd_ready = r_ready;
  assign o_up        = r_up;
  assign o_down      = r_down;
  assign o_load      = r_load;
  assign o_in        = r_in;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_sat       = r_sat;

endmodule

// File: tb/tb_udl_count_ctrl.sv
// Scoreboard bench for udl_count_ctrl with a behavioural counter beside it.
module tb_udl_count_ctrl;

  localparam int W    = 10;
  localparam int MAXV = 1023;

  typedef struct {
    int lat;
    int fin;
    int sat;
    int nu;
    int nd;
    int nl;
    int arg;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cmd_valid = 1'b0;
  logic [1:0]   cmd_op = 2'b00;
  logic [W-1:0] cmd_arg = '0;
  logic         abort = 1'b0;
  logic [W-1:0] cnt_m = '0;
  logic         o_cmd_ready, o_up, o_down, o_load, o_busy, o_done, o_sat;
  logic [W-1:0] o_in;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_done   = 0;
  int   cyc      = 0;
  int   acc      = 0;
  int   mu = 0, md = 0, ml = 0;
  bit   ovl = 1'b0;
  exp_t q[$];

  udl_count_ctrl #(.WIDTH(W)) dut (
    .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_op(cmd_op), .i_cmd_arg(cmd_arg), .i_abort(abort), .i_cnt_q(cnt_m),
    .o_up(o_up), .o_down(o_down), .o_load(o_load), .o_in(o_in),
    .o_busy(o_busy), .o_done(o_done), .o_sat(o_sat)
  );

  always #5 clk = ~clk;

  // Stand-in for UDL_Count: load has priority, otherwise step by one.
  always @(posedge clk) begin
    if (o_load)      cnt_m <= o_in;
    else if (o_up)   cnt_m <= cnt_m + 10'd1;
    else if (o_down) cnt_m <= cnt_m - 10'd1;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference: strobe counts, final count, sat and latency from the command rules.
  function automatic exp_t model(input logic [1:0] op, input int arg, input int st, input int ab);
    exp_t e;
    int   tot, d;
    e = '{default: 0};
    e.arg = arg;
    case (op)
      2'b00: begin e.nl = 1; e.fin = arg; e.lat = 2; end
      2'b01: begin
        tot = (arg < MAXV - st) ? arg : MAXV - st;
        e.sat = (arg > MAXV - st) ? 1 : 0;
        if (ab > 0) begin tot = ab; e.sat = 0; end
        e.nu = tot; e.fin = st + tot; e.lat = tot + 1;
      end
      2'b10: begin
        tot = (arg < st) ? arg : st;
        e.sat = (arg > st) ? 1 : 0;
        if (ab > 0) begin tot = ab; e.sat = 0; end
        e.nd = tot; e.fin = st - tot; e.lat = tot + 1;
      end
      default: begin
        d = (arg > st) ? arg - st : 0;
        tot = 2 * d;
        if (ab > 0) tot = ab;
        e.nu = (tot < d) ? tot : d;
        e.nd = tot - e.nu;
        e.fin = st + e.nu - e.nd;
        e.lat = tot + 1;
      end
    endcase
    return e;
  endfunction

  // Monitor: tracks each accepted command and scores it when done pulses.
  always @(negedge clk) begin
    exp_t e;
    cyc <= cyc + 1;
    if (rst && cmd_valid && o_cmd_ready) begin
      acc <= cyc; mu <= 0; md <= 0; ml <= 0; ovl <= 1'b0;
    end else begin
      mu <= mu + int'(o_up);
      md <= md + int'(o_down);
      ml <= ml + int'(o_load);
      if ((int'(o_up) + int'(o_down) + int'(o_load)) > 1) ovl <= 1'b1;
    end
    if (o_load && q.size() > 0) chk("load_in", int'(o_in), q[0].arg);
    if (o_done) begin
      n_done <= n_done + 1;
      if (q.size() == 0) begin
        n_checks++;
        $display("FAIL spurious_done: got done pulse, expected none");
      end else begin
        e = q.pop_front();
        chk("latency", cyc - acc, e.lat);
        chk("final_count", int'(cnt_m), e.fin);
        chk("sat", int'(o_sat), e.sat);
        chk("up_strobes", mu + int'(o_up), e.nu);
        chk("down_strobes", md + int'(o_down), e.nd);
        chk("load_strobes", ml + int'(o_load), e.nl);
        chk("busy_in_done", int'(o_busy), 1);
        chk("ready_in_done", int'(o_cmd_ready), 0);
        chk("strobe_overlap", int'(ovl), 0);
      end
    end
  end

  // ab_req: 0 no abort, >0 abort in that strobe cycle, -1 random.
  task automatic issue(input logic [1:0] op, input logic [W-1:0] arg, input int ab_req);
    exp_t e;
    int   ab, tot;
    bit   got;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
    got = 1'b0;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk);
      got = o_cmd_ready;
    end
    if (!got) begin
      chk("accept_timeout", 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    e   = model(op, int'(arg), int'(cnt_m), 0);
    tot = e.nu + e.nd + e.nl;
    ab  = ab_req;
    if (ab_req < 0) ab = (tot > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, tot)) : 0;
    if (ab > 0) e = model(op, int'(arg), int'(cnt_m), ab);
    q.push_back(e);
    @(posedge clk); #1;
    cmd_valid = 1'($urandom_range(0, 1));
    cmd_op    = 2'($urandom);
    cmd_arg   = W'($urandom);
    abort     = (ab == 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    abort     = 1'b0;
    if (ab >= 2) begin
      repeat (ab - 2) begin @(posedge clk); #1; end
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
    end
    for (int t = 0; t < 3000 && q.size() != 0; t++) @(negedge clk);
    if (q.size() != 0) begin
      chk("done_timeout", 0, 1);
      q.delete();
    end
    @(negedge clk);
    chk("ready_after_done", int'(o_cmd_ready), 1);
    chk("idle_after_done", int'(o_busy), 0);
  endtask

  initial begin
    logic [1:0]   op;
    logic [W-1:0] arg;
    int           d0;
    bit           got;

    // Reset with a command pulse that must be ignored.
    #30 cmd_valid = 1'b1; cmd_op = 2'b01; cmd_arg = 10'd7;
    #20;
    chk("rst_up", int'(o_up), 0);
    chk("rst_down", int'(o_down), 0);
    chk("rst_load", int'(o_load), 0);
    chk("rst_done", int'(o_done), 0);
    chk("rst_sat", int'(o_sat), 0);
    chk("rst_in", int'(o_in), 0);
    chk("rst_busy", int'(o_busy), 0);
    #10 cmd_valid = 1'b0;
    #52 rst = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", int'(o_cmd_ready), 1);
    repeat (2) @(negedge clk);
    chk("no_accept_in_rst", int'(o_busy), 0);

    // Directed scenarios.
    issue(2'b00, 10'h155, 0);
    issue(2'b00, 10'h3FC, 0);
    issue(2'b01, 10'd5, 0);
    issue(2'b00, 10'h00C, 0);
    issue(2'b11, 10'h010, 0);
    issue(2'b00, 10'h020, 0);
    issue(2'b10, 10'd0, 0);
    issue(2'b11, 10'h005, 0);
    issue(2'b00, 10'h003, 0);
    issue(2'b10, 10'd9, 0);
    issue(2'b00, 10'h000, 0);
    issue(2'b01, 10'd100, 10);

    // Randomized commands biased towards the range limits.
    for (int i = 0; i < 60; i++) begin
      op = 2'($urandom_range(0, 3));
      case (op)
        2'b00: begin
          case ($urandom_range(0, 2))
            0:       arg = W'($urandom_range(0, 6));
            1:       arg = W'(MAXV - int'($urandom_range(0, 6)));
            default: arg = W'($urandom_range(0, MAXV));
          endcase
        end
        2'b01, 2'b10: arg = W'($urandom_range(0, 24));
        default: begin
          if ($urandom_range(0, 2) == 0) arg = W'($urandom_range(0, int'(cnt_m)));
          else begin
            d0  = int'(cnt_m) + int'($urandom_range(0, 20));
            arg = W'((d0 > MAXV) ? MAXV : d0);
          end
        end
      endcase
      issue(op, arg, -1);
    end

    // Reset in the middle of a step command: strobes drop, no done follows.
    issue(2'b00, 10'h100, 0);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_arg = 10'd50;
    got = 1'b0;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk);
      got = o_cmd_ready;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_up", int'(o_up), 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_up", int'(o_up), 0);
    chk("mid_rst_busy", int'(o_busy), 0);
    chk("mid_rst_done", int'(o_done), 0);
    d0 = n_done;
    #20 rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("no_done_after_rst", n_done, d0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/udl_count_ctrl.md
Name: udl_count_ctrl

Overview:
Command-driven sequencer for the parameterised up/down/load counter (UDL_Count).
- Accepts one command at a time over a valid/ready handshake.
- Drives the counter's up/down/load/in strobes so that at most one strobe is active per cycle.
- Tracks a shadow copy of the count so it can stop cleanly at the range limits.
- Sits beside the counter at the same hierarchy level; the counter's out feeds back as cnt_q.

Parameters:
WIDTH, 10, counter/argument width; MAX = 2^WIDTH-1.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  controller can accept a command (high only in IDLE)
cmd_op  in  2  00 LOAD, 01 UP, 10 DOWN, 11 SWEEP
cmd_arg  in  WIDTH  LOAD value / step count (UP, DOWN) / sweep peak (SWEEP)
abort  in  1  terminate the active command
cnt_q  in  WIDTH  counter output, sampled at command acceptance
up  out  1  counter increment strobe
down  out  1  counter decrement strobe
load  out  1  counter load strobe
in  out  WIDTH  counter load value
busy  out  1  state != IDLE
done  out  1  one-cycle completion pulse
sat  out  1  last command stopped at 0 or MAX; cleared on next accept

Behaviour:
- Reset (rst=0, async): state=IDLE; up/down/load/done/sat=0, in=0, busy=0. cmd_ready=1 once rst=1.
  - Reset mid-command drops all strobes immediately. The command is lost and no done is issued.
- Accept: cmd_valid&cmd_ready at edge E0.
  - Latch op and arg; shadow<=cnt_q; start<=cnt_q; remaining<=arg; sat<=0.
  - cmd_valid while busy is ignored and is not queued.
- Strobes are Moore outputs decoded from the state register. up, down and load are mutually exclusive in every cycle.
- States: IDLE, LOAD, STEP_UP, STEP_DN, SWEEP_UP, SWEEP_DN, DONE.
- LOAD: cycle after E0 has load=1, in=arg. Next cycle is DONE. shadow<=arg.
- UP (n=arg):
  - n=0 goes straight to DONE.
  - Otherwise STEP_UP: up=1 per cycle while remaining>0 and shadow<MAX; shadow++ and remaining-- each strobe.
  - remaining reaching 0 goes to DONE.
  - shadow==MAX with remaining>0: no strobe, sat<=1, go to DONE. The counter never wraps.
- DOWN: mirror of UP, floor 0, sets sat when 0 is reached with remaining>0.
- SWEEP (peak=arg):
  - SWEEP_UP strobes up until shadow==peak.
  - Then SWEEP_DN strobes down until shadow==start, then DONE.
  - peak<=start skips the up phase entirely, so 0 strobes if peak==start.
  - Total strobes = 2*(peak-start) when peak>start. sat is never set.
- DONE: one cycle with done=1, busy=1, cmd_ready=0. Then IDLE.
- abort:
  - Sampled at each edge in LOAD/STEP_*/SWEEP_*. The strobe already driven in that cycle takes effect.
  - Next state is DONE; sat is unchanged.
  - abort in IDLE or DONE is ignored.
- Latency: command of k strobes gives done in cycle E0+k+1. LOAD: done at E0+2.
- Arithmetic: shadow and remaining are WIDTH bits unsigned. Comparisons guard every increment or decrement, so no overflow is possible.

Decomposition:
- Shared package udl_ctrl_pkg holds:
  - op_t enum (OP_LOAD, OP_UP, OP_DOWN, OP_SWEEP)
  - state_t enum
  - function max_val(WIDTH)
- No sub-module: a single FSM with shadow, start and remaining registers.
- UDL_Count is instantiated next to this block at the top level, not inside it.

Test Plan:
1. Hold rst=0 for 112 ns, pulse cmd_valid during reset -> all strobes/done/sat=0, in=0, busy=0; cmd_ready=1 after release; no command accepted.
2. LOAD 0x155 -> load=1, in=0x155 for exactly 1 cycle; done at E0+2; counter out=0x155.
3. LOAD 0x3FC, then UP 5 -> up high 3 cycles, counter 0x3FF, sat=1, done at E0+4; no wrap to 0x000.
4. LOAD 0x00C, then SWEEP 0x010 -> 4 up cycles then 4 down cycles, never overlapping; out returns to 0x00C; done at E0+9; sat=0.
5. DOWN 0 from 0x020, and SWEEP 0x005 from 0x020 -> zero strobes each; done at E0+1; count stays 0x020.
6. UP 100 from 0x000, abort asserted in the 10th strobe cycle -> up drops next cycle, done pulses, count=0x00A, sat=0, cmd_ready returns 1.
